// File: rtl/tt_mask_idx_gen.sv
// Mask/index item generator for vector memops: streams 65-bit {mask, index|maskword}
// items to the LSU under credit flow control, with indices fed through a chunk FIFO.
module tt_mask_idx_gen #(
   parameter int VLEN         = 256,
   parameter int MASK_CREDITS = 2,
   parameter int IDX_CHUNKS   = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_memop_sync_start,
   input  logic                       i_abort,
   input  logic                       i_is_masked_memop,
   input  logic                       i_is_indexed,
   input  logic [$clog2(VLEN+1)-1:0]  i_vl,
   input  logic [1:0]                 i_eew,
   input  logic [VLEN-1:0]            i_mask_data,
   input  logic [VLEN-1:0]            i_index_data,
   input  logic                       i_index_data_valid,
   input  logic                       i_mask_idx_credit,
   output logic                       o_mask_idx_valid,
   output logic [64:0]                o_mask_idx_item,
   output logic                       o_mask_idx_last_idx,
   output logic                       o_busy,
   output logic                       o_idx_ovf
);
   localparam int VLW  = $clog2(VLEN+1);
   localparam int EW   = $clog2(VLEN);
   localparam int BW   = $clog2(VLEN/8);
   localparam int EPC8 = VLEN/8;
   localparam int NW   = VLEN/64;
   localparam int WW   = (NW > 1) ? $clog2(NW) : 1;
   localparam int CW   = $clog2(MASK_CREDITS+1);
   localparam int PW   = (IDX_CHUNKS > 1) ? $clog2(IDX_CHUNKS) : 1;
   localparam int FW   = $clog2(IDX_CHUNKS+1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   typedef struct packed {
      logic [1:0] eew;
      logic       indexed;
   } op_t;

   logic [0:0]          state;
   op_t                 op_q;
   logic [VLEN-1:0]     mask_q;
   logic [VLW-1:0]      rem_q;
   logic [EW-1:0]       ptr_q;
   logic [BW-1:0]       off_q;
   logic [CW-1:0]       credits_q;
   logic [VLEN-1:0]     fifo [IDX_CHUNKS];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [FW-1:0]       cnt;
   logic                valid_q, last_q, ovf_q;
   logic [64:0]         item_q;

   // Per-bit tail mask: element positions >= vl never reach the LSU as active.
   logic [VLEN-1:0] vl_mask;
   for (genvar i = 0; i < VLEN; i++) begin : g_vlm
      assign vl_mask[i] = (VLW'(i) < i_vl);
   end

   logic [CW:0] cred_nxt;
   logic [CW-1:0] cred_d;
   assign cred_nxt = {1'b0, credits_q} + (CW+1)'(i_mask_idx_credit) - (CW+1)'(valid_q);
   assign cred_d   = (cred_nxt > (CW+1)'(MASK_CREDITS)) ? CW'(MASK_CREDITS) : cred_nxt[CW-1:0];

   logic fifo_empty, fifo_full, last_item, issue, pop, wr_req, push, ovf;
   logic start_idle, start_go;
   assign fifo_empty = (cnt == '0);
   assign fifo_full  = (cnt == FW'(IDX_CHUNKS));
   assign last_item  = (rem_q == VLW'(1));
   assign issue      = (state == SEND) && !i_abort && (cred_nxt != '0) && (rem_q != '0)
                       && (!op_q.indexed || !fifo_empty);
   assign start_idle = i_memop_sync_start && (state == IDLE) && !i_abort;
   assign start_go   = start_idle && (i_is_masked_memop || i_is_indexed) && (i_vl != '0);

   // Element offset inside the head chunk, in bits, scaled by the index width.
   logic [EW-1:0] sh_amt;
   logic [63:0]   elem_raw, elem;
   logic [BW-1:0] epc_m1;
   assign sh_amt   = {off_q, 3'b000} << op_q.eew;
   assign elem_raw = 64'(fifo[rd_ptr] >> sh_amt);

   always_comb begin
      elem   = elem_raw;
      epc_m1 = BW'(EPC8/8 - 1);
      case (op_q.eew)
         2'd0: begin elem = {56'd0, elem_raw[7:0]};  epc_m1 = BW'(EPC8 - 1);   end
         2'd1: begin elem = {48'd0, elem_raw[15:0]}; epc_m1 = BW'(EPC8/2 - 1); end
         2'd2: begin elem = {32'd0, elem_raw[31:0]}; epc_m1 = BW'(EPC8/4 - 1); end
         default: ;
      endcase
   end

   logic [NW-1:0][63:0] mask_words;
   logic [64:0]         item_d;
   assign mask_words = mask_q;
   assign item_d     = op_q.indexed ? {mask_q[ptr_q], elem} : {1'b1, mask_words[ptr_q[WW-1:0]]};

   // A chunk retires after its final element, or early when the memop's last item leaves.
   assign pop    = issue && op_q.indexed && ((off_q == epc_m1) || last_item);
   assign wr_req = i_index_data_valid && (i_is_indexed || ((state == SEND) && op_q.indexed));
   assign push   = wr_req && !i_abort && (!fifo_full || pop);
   assign ovf    = wr_req && fifo_full && !pop;

   logic [VLW:0]   vl_up;
   logic [VLW-1:0] rem_init;
   assign vl_up    = {1'b0, i_vl} + (VLW+1)'(63);
   assign rem_init = i_is_indexed ? i_vl : VLW'(vl_up >> 6);

   always_ff @(posedge i_clk) begin
      if (push) fifo[wr_ptr] <= i_index_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state     <= IDLE;
         op_q      <= '0;
         mask_q    <= '0;
         rem_q     <= '0;
         ptr_q     <= '0;
         off_q     <= '0;
         credits_q <= CW'(MASK_CREDITS);
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         valid_q   <= 1'b0;
         item_q    <= '0;
         last_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         credits_q <= cred_d;
         valid_q   <= issue;
         last_q    <= issue && last_item;
         ovf_q     <= ovf;
         if (issue) item_q <= item_d;

         if (i_abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(IDX_CHUNKS-1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(IDX_CHUNKS-1)) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + FW'(push) - FW'(pop);
         end

         if (i_abort) begin
            state <= IDLE;
            rem_q <= '0;
         end else if (state == IDLE) begin
            if (start_idle) begin
               op_q   <= '{eew: i_eew, indexed: i_is_indexed};
               mask_q <= (i_is_masked_memop ? i_mask_data : {VLEN{1'b1}}) & vl_mask;
            end
            if (start_go) begin
               state <= SEND;
               rem_q <= rem_init;
               ptr_q <= '0;
               off_q <= '0;
            end
         end else if (issue) begin
            rem_q <= rem_q - 1'b1;
            ptr_q <= ptr_q + 1'b1;
            off_q <= (off_q == epc_m1) ? '0 : off_q + 1'b1;
            if (last_item) state <= IDLE;
         end
      end
   end

   assign o_mask_idx_valid    = valid_q;
   assign o_mask_idx_item     = item_q;
   assign o_mask_idx_last_idx = last_q;
   assign o_busy              = (state == SEND);
   assign o_idx_ovf           = ovf_q;

   a_credit_ovf: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      !(i_mask_idx_credit && !valid_q && (credits_q == CW'(MASK_CREDITS))));
endmodule

// File: tb/tb_tt_mask_idx_gen.sv
// Directed bench for tt_mask_idx_gen: strided, indexed, streaming, credit stall,
// vl=0, abort and FIFO overflow, against hand-computed items.
module tb_tt_mask_idx_gen;
   localparam int VLEN = 256;
   localparam int VLW  = $clog2(VLEN+1);

   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic            i_reset_n = 1'b0;
   logic            i_memop_sync_start = 1'b0, i_abort = 1'b0;
   logic            i_is_masked_memop = 1'b0, i_is_indexed = 1'b0;
   logic [VLW-1:0]  i_vl = '0;
   logic [1:0]      i_eew = '0;
   logic [VLEN-1:0] i_mask_data = '0, i_index_data = '0;
   logic            i_index_data_valid = 1'b0, i_mask_idx_credit = 1'b0;
   logic            o_mask_idx_valid, o_mask_idx_last_idx, o_busy, o_idx_ovf;
   logic [64:0]     o_mask_idx_item;

   logic            d2_idx = 1'b0, d2_vld = 1'b0, d2_zero = 1'b0;
   logic [VLW-1:0]  d2_vl = '0;
   logic [1:0]      d2_eew = '0;
   logic [VLEN-1:0] d2_mask = '0, d2_data = '0;
   logic            d2_valid, d2_last, d2_busy, d2_ovf;
   logic [64:0]     d2_item;

   tt_mask_idx_gen #(.VLEN(VLEN), .MASK_CREDITS(2), .IDX_CHUNKS(8)) u_dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_memop_sync_start(i_memop_sync_start), .i_abort(i_abort),
      .i_is_masked_memop(i_is_masked_memop), .i_is_indexed(i_is_indexed),
      .i_vl(i_vl), .i_eew(i_eew), .i_mask_data(i_mask_data),
      .i_index_data(i_index_data), .i_index_data_valid(i_index_data_valid),
      .i_mask_idx_credit(i_mask_idx_credit),
      .o_mask_idx_valid(o_mask_idx_valid), .o_mask_idx_item(o_mask_idx_item),
      .o_mask_idx_last_idx(o_mask_idx_last_idx), .o_busy(o_busy), .o_idx_ovf(o_idx_ovf));

   tt_mask_idx_gen #(.VLEN(VLEN), .MASK_CREDITS(2), .IDX_CHUNKS(2)) u_dut2 (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_memop_sync_start(d2_zero), .i_abort(d2_zero),
      .i_is_masked_memop(d2_zero), .i_is_indexed(d2_idx),
      .i_vl(d2_vl), .i_eew(d2_eew), .i_mask_data(d2_mask),
      .i_index_data(d2_data), .i_index_data_valid(d2_vld),
      .i_mask_idx_credit(d2_zero),
      .o_mask_idx_valid(d2_valid), .o_mask_idx_item(d2_item),
      .o_mask_idx_last_idx(d2_last), .o_busy(d2_busy), .o_idx_ovf(d2_ovf));

   int n_chk = 0, n_fail = 0, cyc = 0, stray_last = 0, wcyc = 0;
   logic auto_cr = 1'b0, man_cr = 1'b0;
   logic [64:0] item_q[$];
   logic        lst_q[$];
   int          cyc_q[$];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: sample #1 after the edge, log items, then drive this cycle's credit.
   task automatic tick();
      @(posedge i_clk); #1;
      cyc++;
      if (o_mask_idx_valid) begin
         item_q.push_back(o_mask_idx_item);
         lst_q.push_back(o_mask_idx_last_idx);
         cyc_q.push_back(cyc);
      end else if (o_mask_idx_last_idx) stray_last++;
      i_mask_idx_credit = (auto_cr && o_mask_idx_valid) || man_cr;
      man_cr = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   function automatic logic [64:0] itm(input int i);
      return (i < item_q.size()) ? item_q[i] : 65'bx;
   endfunction

   function automatic logic [7:0] lastv();
      logic [7:0] v = '0;
      for (int i = 0; i < item_q.size() && i < 8; i++) v[i] = lst_q[i];
      return v;
   endfunction

   function automatic logic [7:0] maskv();
      logic [7:0] v = '0;
      for (int i = 0; i < item_q.size() && i < 8; i++) v[i] = item_q[i][64];
      return v;
   endfunction

   task automatic clr_log();
      item_q.delete(); lst_q.delete(); cyc_q.delete();
   endtask

   task automatic start(input logic m, input logic x, input int vl, input logic [1:0] eew,
                        input logic [VLEN-1:0] mask, input logic wr, input logic [VLEN-1:0] data);
      i_is_masked_memop = m; i_is_indexed = x; i_vl = VLW'(vl); i_eew = eew;
      i_mask_data = mask; i_index_data = data; i_index_data_valid = wr;
      i_memop_sync_start = 1'b1;
      tick();
      i_memop_sync_start = 1'b0; i_index_data_valid = 1'b0; i_is_indexed = 1'b0;
   endtask

   localparam logic [63:0] W0 = 64'h0123456789ABCDEF, W1 = 64'hFEDCBA9876543210;
   localparam logic [63:0] W2 = 64'h5555555555555555, W3 = 64'hAAAAAAAAAAAAAAAA;

   initial begin
      // reset
      ticks(3);
      chk("rst_valid", o_mask_idx_valid, 0);
      chk("rst_item", o_mask_idx_item, 0);
      chk("rst_busy", {o_busy, o_mask_idx_last_idx, o_idx_ovf}, 0);
      i_reset_n = 1'b1;
      tick();
      chk("rst_post_busy", o_busy, 0);

      // 1: strided masked vl=130, v0 all ones, credits returned with each item
      auto_cr = 1'b1; clr_log();
      start(1'b1, 1'b0, 130, 2'd0, {VLEN{1'b1}}, 1'b0, '0);
      chk("t1_busy", o_busy, 1);
      ticks(10);
      chk("t1_cnt", item_q.size(), 3);
      chk("t1_i0", itm(0), {1'b1, 64'hFFFFFFFFFFFFFFFF});
      chk("t1_i1", itm(1), {1'b1, 64'hFFFFFFFFFFFFFFFF});
      chk("t1_i2", itm(2), {1'b1, 64'h3});
      chk("t1_last", lastv(), 8'b100);
      chk("t1_consec", (cyc_q.size() == 3) ? cyc_q[2] - cyc_q[0] : -1, 2);
      chk("t1_idle", o_busy, 0);

      // 2: indexed unmasked eew=8b, vl=5
      clr_log();
      start(1'b0, 1'b1, 5, 2'd0, '0, 1'b1, {216'd0, 40'h04030201FF});
      ticks(10);
      chk("t2_cnt", item_q.size(), 5);
      chk("t2_i0", itm(0), {1'b1, 64'hFF});
      chk("t2_i1", itm(1), {1'b1, 64'h1});
      chk("t2_i4", itm(4), {1'b1, 64'h4});
      chk("t2_last", lastv(), 8'b10000);

      // 3: indexed eew=64b, masked, chunk1 arrives 5 cycles after start
      clr_log();
      start(1'b1, 1'b1, 6, 2'd3, {250'd0, 6'b101101}, 1'b1,
            {64'h3, 64'h2, W0, 64'h8000000000000001});
      ticks(4);
      i_index_data = {128'd0, 64'hBEEF, 64'hDEAD}; i_index_data_valid = 1'b1;
      wcyc = cyc;
      tick();
      i_index_data_valid = 1'b0;
      ticks(8);
      chk("t3_cnt", item_q.size(), 6);
      chk("t3_i0", itm(0), {1'b1, 64'h8000000000000001});
      chk("t3_i1", itm(1), {1'b0, W0});
      chk("t3_i4", itm(4), {1'b0, 64'hDEAD});
      chk("t3_i5", itm(5), {1'b1, 64'hBEEF});
      chk("t3_mask", maskv(), 8'b101101);
      chk("t3_last", lastv(), 8'b100000);
      chk("t3_early", (cyc_q.size() == 6) ? (cyc_q[3] <= wcyc && cyc_q[4] > wcyc) : 0, 1);

      // 4: credit stall, strided vl=256
      auto_cr = 1'b0; clr_log();
      start(1'b1, 1'b0, 256, 2'd0, {W3, W2, W1, W0}, 1'b0, '0);
      ticks(8);
      chk("t4_stall_cnt", item_q.size(), 2);
      chk("t4_i0", itm(0), {1'b1, W0});
      chk("t4_i1", itm(1), {1'b1, W1});
      chk("t4_stall_busy", o_busy, 1);
      man_cr = 1'b1; ticks(6);
      chk("t4_one_more", item_q.size(), 3);
      chk("t4_i2", itm(2), {1'b1, W2});
      man_cr = 1'b1; ticks(6);
      chk("t4_i3", itm(3), {1'b1, W3});
      chk("t4_last", lastv(), 8'b1000);
      chk("t4_idle", o_busy, 0);
      man_cr = 1'b1; tick(); man_cr = 1'b1; ticks(3);

      // 5a: vl=0 masked start
      clr_log();
      start(1'b1, 1'b0, 0, 2'd0, {VLEN{1'b1}}, 1'b0, '0);
      chk("t5_vl0_busy", o_busy, 0);
      ticks(4);
      chk("t5_vl0_items", item_q.size(), 0);

      // 5b: abort after 2 of 5 items, then prove the FIFO was flushed
      start(1'b0, 1'b1, 5, 2'd0, '0, 1'b1, {216'd0, 40'h04030201FF});
      ticks(6);
      chk("t5_pre_abort", item_q.size(), 2);
      i_abort = 1'b1; tick(); i_abort = 1'b0;
      chk("t5_abort_idle", o_busy, 0);
      man_cr = 1'b1; tick(); man_cr = 1'b1; ticks(5);
      chk("t5_no_more", item_q.size(), 2);
      chk("t5_no_last", {stray_last[7:0], lastv()}, 0);
      auto_cr = 1'b1;
      start(1'b0, 1'b1, 1, 2'd0, '0, 1'b0, '0);
      ticks(5);
      chk("t5_flushed", item_q.size(), 2);
      chk("t5_wait_busy", o_busy, 1);
      i_index_data = {248'd0, 8'h07}; i_index_data_valid = 1'b1;
      tick();
      i_index_data_valid = 1'b0;
      ticks(4);
      chk("t5_new_item", itm(2), {1'b1, 64'h7});
      chk("t5_new_last", lastv(), 8'b100);

      // 6: overflow on a 2-deep FIFO that cannot drain
      d2_idx = 1'b1; d2_vld = 1'b1; d2_data = {VLEN{1'b1}};
      tick(); chk("t6_ovf_w1", d2_ovf, 0);
      tick(); chk("t6_ovf_w2", d2_ovf, 0);
      tick(); chk("t6_ovf_w3", d2_ovf, 1);
      d2_vld = 1'b0;
      tick(); chk("t6_ovf_pulse", d2_ovf, 0);
      chk("t6_no_item", d2_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
